// File: rtl/shift_sweep_sequencer.sv
// rtl/shift_sweep_sequencer.sv - registered command/result sequencer around an external rotate shifter
// Optional reference-rotator self-check enabled by SHIFT_SWEEP_CHECK_EN.
module shift_sweep_sequencer #(
    parameter  int N = 3,
    localparam int W = 2**N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_lr,
    input  logic         in_sweep,
    input  logic [N-1:0] in_amt,
    output logic [W-1:0] sh_a,
    output logic [N-1:0] sh_amt,
    output logic         sh_lr,
    input  logic [W-1:0] sh_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [N-1:0] out_amt,
    output logic         out_last,
    output logic         busy,
    output logic         chk_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t         state_q;
    logic           in_ready_q;
    logic           sweep_q;
    logic [W-1:0]   sh_a_q;
    logic [N-1:0]   sh_amt_q;
    logic [N-1:0]   sh_amt_d;
    logic           sh_lr_q;
    logic           out_valid_q;
    logic [W-1:0]   out_data_q;
    logic [N-1:0]   out_amt_q;
    logic           out_last_q;

    assign sh_amt_d = sh_amt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            sweep_q     <= 1'b0;
            sh_a_q      <= '0;
            sh_amt_q    <= '0;
            sh_lr_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_amt_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        sh_a_q     <= in_data;
                        sh_lr_q    <= in_lr;
                        sh_amt_q   <= in_sweep ? '0 : in_amt;
                        sweep_q    <= in_sweep;
                        in_ready_q <= 1'b0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    out_data_q  <= sh_y;
                    out_amt_q   <= sh_amt_q;
                    out_last_q  <= !sweep_q || (sh_amt_q == '1);
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            in_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            // A sweep stops at all-ones, so the increment never wraps.
                            sh_amt_q <= sh_amt_d;
                            state_q  <= ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign sh_a      = sh_a_q;
    assign sh_amt    = sh_amt_q;
    assign sh_lr     = sh_lr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_amt   = out_amt_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);

`ifdef SHIFT_SWEEP_CHECK_EN
    logic [2*W-1:0] rot_ext;
    logic [W-1:0]   ref_y;
    logic           chk_err_q;

    // Rotating a doubled word turns wrap-around into a plain shift.
    always_comb begin
        rot_ext = '0;
        ref_y   = '0;
        if (sh_lr_q) begin
            rot_ext = {sh_a_q, sh_a_q} >> sh_amt_q;
            ref_y   = rot_ext[W-1:0];
        end else begin
            rot_ext = {sh_a_q, sh_a_q} << sh_amt_q;
            ref_y   = rot_ext[2*W-1:W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_err_q <= 1'b0;
        end else if (state_q == ISSUE && sh_y != ref_y) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sweep_sequencer.sv
// tb/tb_shift_sweep_sequencer.sv - scoreboard bench for shift_sweep_sequencer
// Honours SHIFT_SWEEP_CHECK_EN for the chk_err expectations.
module tb_shift_sweep_sequencer;

    localparam int N = 3;
    localparam int W = 8;
`ifdef SHIFT_SWEEP_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_lr;
    logic         in_sweep;
    logic [N-1:0] in_amt;
    logic [W-1:0] sh_a;
    logic [N-1:0] sh_amt;
    logic         sh_lr;
    logic [W-1:0] sh_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [N-1:0] out_amt;
    logic         out_last;
    logic         busy;
    logic         chk_err;

    shift_sweep_sequencer #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_lr(in_lr), .in_sweep(in_sweep), .in_amt(in_amt),
        .sh_a(sh_a), .sh_amt(sh_amt), .sh_lr(sh_lr), .sh_y(sh_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_amt(out_amt), .out_last(out_last), .busy(busy), .chk_err(chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    bit corrupt = 1'b0;

    always_comb begin
        sh_y = '0;
        for (int i = 0; i < W; i++) begin
            if (sh_lr) sh_y[i] = sh_a[(i + int'(sh_amt)) % W];
            else       sh_y[(i + int'(sh_amt)) % W] = sh_a[i];
        end
        if (corrupt && sh_amt == 3'd5) sh_y[0] = ~sh_y[0];
    end

    typedef struct packed {
        logic         last;
        logic [N-1:0] amt;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   pops = 0;
    logic [7:0] left_tbl  [8] = '{8'hC6, 8'h8D, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hB1, 8'h63};
    logic [7:0] right_tbl [8] = '{8'hC6, 8'h63, 8'hB1, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'h8D};

    bit   stall = 1'b0;
    exp_t held;
    exp_t e;

    always @(negedge clk) begin
        if (!reset_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_fields", 32'({out_last, out_amt, out_data}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_amt",  32'(out_amt),  32'(e.amt));
                    check("out_last", 32'(out_last), 32'(e.last));
                    pops++;
                    if (corrupt && out_amt == 3'd4) check("chk_err_pre", 32'(chk_err), 32'd0);
                    if (corrupt && out_amt == 3'd5) check("chk_err_rise", 32'(chk_err), 32'(CHK_EN));
                end
            end
            stall = out_valid && !out_ready;
            held  = {out_last, out_amt, out_data};
        end
    end

    int cyc = 0, acc_cyc = 0, last_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) acc_cyc <= cyc;
        if (out_valid && out_ready && out_last) last_cyc <= cyc;
    end

    task automatic send_cmd(input logic [7:0] d, input logic lr, input logic sw, input logic [2:0] amt);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
        in_data = d; in_lr = lr; in_sweep = sw; in_amt = amt; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push_sweep(input logic lr);
        for (int a = 0; a < 8; a++) begin
            exp_t x;
            x.last = (a == 7);
            x.amt  = 3'(a);
            x.data = lr ? right_tbl[a] : left_tbl[a];
            if (corrupt && a == 5) x.data[0] = ~x.data[0];
            sb.push_back(x);
        end
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        if (sb.size() != 0 || busy) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic single(input logic [7:0] d, input logic lr, input logic [2:0] amt, input logic [7:0] exp);
        sb.push_back({1'b1, amt, exp});
        send_cmd(d, lr, 1'b0, amt);
        drain(1'b0);
        check("ready_after_single", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int base, n;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_lr = 1'b0;
        in_sweep = 1'b0; in_amt = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_chk_err",   32'(chk_err),   32'd0);
        check("rst_sh_a",      32'(sh_a),      32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        sb.push_back({1'b1, 3'd1, 8'h8D});
        send_cmd(8'hC6, 1'b0, 1'b0, 3'd1);
        @(negedge clk);
        check("lat_t_plus1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_t_plus2", 32'(out_valid), 32'd1);
        drain(1'b0);
        check("single_latency", 32'(last_cyc - acc_cyc), 32'd2);
        check("ready_after_single", 32'(in_ready), 32'd1);

        single(8'hC6, 1'b1, 3'd1, 8'h63);
        single(8'hC6, 1'b0, 3'd4, 8'h6C);
        single(8'hC6, 1'b0, 3'd0, 8'hC6);
        single(8'hC6, 1'b1, 3'd0, 8'hC6);

        base = pops;
        push_sweep(1'b0);
        send_cmd(8'hC6, 1'b0, 1'b1, 3'd5);
        drain(1'b0);
        check("left_sweep_count", 32'(pops - base), 32'd8);
        check("left_sweep_cycles", 32'(last_cyc - acc_cyc), 32'd16);

        base = pops;
        push_sweep(1'b1);
        send_cmd(8'hC6, 1'b1, 1'b1, 3'd2);
        drain(1'b1);
        check("right_sweep_count", 32'(pops - base), 32'd8);

        base = pops;
        push_sweep(1'b0);
        send_cmd(8'hC6, 1'b0, 1'b1, 3'd0);
        n = 0;
        while (pops < base + 3 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_sweep_progress", 32'(pops - base), 32'd3);
        #1 reset_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_abort", 32'(in_ready), 32'd1);
        single(8'hC6, 1'b1, 3'd1, 8'h63);

        check("chk_err_clean", 32'(chk_err), 32'd0);
        corrupt = 1'b1;
        push_sweep(1'b0);
        send_cmd(8'hC6, 1'b0, 1'b1, 3'd0);
        drain(1'b0);
        corrupt = 1'b0;
        check("chk_err_sticky", 32'(chk_err), 32'(CHK_EN));
        single(8'hC6, 1'b0, 3'd4, 8'h6C);
        check("chk_err_sticky2", 32'(chk_err), 32'(CHK_EN));
        #1 reset_n = 1'b0;
        #1;
        check("chk_err_cleared", 32'(chk_err), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_sweep_sequencer.md
Name: shift_sweep_sequencer

Overview:
- Registered command stage that drives the combinational rotate/reverse barrel shifter: accepts a data word plus direction over valid/ready and presents `sh_a`/`sh_amt`/`sh_lr` to the shifter.
- Captures the shifter's `sh_y` and streams results downstream over valid/ready.
- Two modes: single rotate by a requested amount, or a full sweep of all amounts 0..2^N-1.
- Sits between the command source and the result consumer; the shifter itself stays external.

Parameters:
- N, 3, shift-amount width; data width W = 2**N.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command ready; high only in IDLE.
- in_data  input  W  word to rotate.
- in_lr  input  1  0 = rotate left, 1 = rotate right.
- in_sweep  input  1  0 = single rotate by in_amt, 1 = sweep amounts 0..2^N-1.
- in_amt  input  N  amount for single mode; ignored in sweep mode.
- sh_a  output  W  to shifter data input (registered).
- sh_amt  output  N  to shifter amount (registered).
- sh_lr  output  1  to shifter direction (registered).
- sh_y  input  W  shifter result (combinational from sh_*).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream ready.
- out_data  output  W  captured rotate result.
- out_amt  output  N  amount that produced out_data.
- out_last  output  1  final result of current command.
- busy  output  1  high whenever state != IDLE.
- chk_err  output  1  sticky self-check error (see Optional Feature).

Behaviour:
- Reset (async, reset_n low): state=IDLE, in_ready=0, all other outputs 0, sweep flag cleared. in_ready rises on the first clk edge after reset_n deasserts.
- States: IDLE, ISSUE, HOLD.
- IDLE: in_ready=1. On in_valid & in_ready:
  - load sh_a=in_data, sh_lr=in_lr, sh_amt = in_sweep ? 0 : in_amt; latch sweep flag.
  - go to ISSUE; in_ready drops the next cycle.
- ISSUE (one cycle, sh_* stable):
  - capture out_data=sh_y, out_amt=sh_amt.
  - out_last = !sweep | (sh_amt == 2^N-1).
  - set out_valid; go to HOLD.
- HOLD: out_valid=1; out_data, out_amt, out_last held stable until out_ready.
  - On out_ready with out_last=1: clear out_valid, go to IDLE.
  - On out_ready with out_last=0: clear out_valid, sh_amt=sh_amt+1 (N-bit, never wraps inside a sweep), go to ISSUE.
- Latency:
  - Command accept at edge T gives out_valid at edge T+2.
  - Sweep with out_ready tied high produces 2^N results, one every 2 cycles; out_valid toggles.
  - The next command can be accepted at edge T_last+1, where T_last is the final handshake edge.
- out_valid never drops without a handshake; in_valid is ignored outside IDLE.
- sh_* hold their value in IDLE after a command completes (no zeroing).
- Rotation semantics (owned by the shifter, relied on by the checker): left = bits move toward MSB with MSB wrapping into LSB; right = the inverse. amt=0 is a pass-through.
- busy = (state != IDLE).
- Reset mid-command aborts immediately: outputs return to reset values and no partial result is emitted afterwards.

Optional Feature:
- Macro SHIFT_SWEEP_CHECK_EN.
- Defined:
  - An internal reference rotator computes the expected result from sh_a/sh_amt/sh_lr.
  - In ISSUE, a mismatch with sh_y sets chk_err.
  - chk_err is sticky, cleared only by reset_n, and does not stall the data path.
- Undefined: no reference logic; chk_err tied to 0.

Test Plan:
- Single left rotate: in_data=8'hC6, in_lr=0, in_sweep=0, in_amt=1, out_ready=1 -> out_data=8'h8D, out_amt=1, out_last=1, out_valid exactly 2 edges after accept, in_ready back high after the handshake.
- Single right rotate: 8'hC6, in_lr=1, in_amt=1 -> 8'h63. Same word, in_lr=0, in_amt=4 -> 8'h6C. Amount 0 in either direction -> 8'hC6.
- Left sweep with out_ready=1: 8'hC6 -> out_amt 0..7, out_data C6, 8D, 1B, 36, 6C, D8, B1, 63; out_last only on amt 7; 16 cycles accept-to-last.
- Right sweep with out_ready toggled randomly: out_data, out_amt, out_last stay stable while out_valid=1 & out_ready=0. Sequence C6, 63, B1, D8, 6C, 36, 1B, 8D; no result lost or duplicated.
- Reset mid-sweep: assert reset_n=0 after the 3rd result -> out_valid=0, busy=0, in_ready=0 immediately. After release, in_ready=1 next edge and a fresh single command completes correctly.
- With SHIFT_SWEEP_CHECK_EN: a bench shifter model that corrupts bit 0 at amt=5 -> chk_err rises after the ISSUE cycle for amt 5 and stays high through later commands until reset. Without the macro -> chk_err=0 throughout.
